// File: rtl/encode_reg_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : encode_reg_arb_if
//  Description : Request/grant bundle between register-select requesters,
//                the encode_reg_arb arbiter and the grant consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface encode_reg_arb_if;
  // Request vector in decoder bit order: bit7=r0 ... bit0=r7
  logic [7:0] req;
  // Consumer accepts the current grant when ready and valid are both high
  logic       ready;
  // Grant outputs hold a live grant
  logic       valid;
  // Granted register number, r0=000 ... r7=111
  logic [2:0] reg_num;
  // One-hot grant in decoder bit order, zero when valid is low
  logic [7:0] grant;
  // Current round-robin start register (visibility only)
  logic [2:0] ptr;

  // Requester/consumer side
  modport master (
    output req,
    output ready,
    input  valid,
    input  reg_num,
    input  grant,
    input  ptr
  );

  // Arbiter side
  modport slave (
    input  req,
    input  ready,
    output valid,
    output reg_num,
    output grant,
    output ptr
  );
endinterface
`default_nettype wire

// File: rtl/encode_reg_arb.sv
`default_nettype none
// ============================================================================
//  Module      : encode_reg_arb
//  Description : Sequential encoder/arbiter for register-select requests.
//                Grants one requester at a time, presenting its 3-bit
//                register number and a one-hot echo, with a valid/ready
//                handshake toward the consumer. Round-robin by default,
//                fixed priority (r0 highest) when FIXED_PRIORITY=1.
//  Revision    : 1.0 - initial release
// ============================================================================
module encode_reg_arb #(
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  encode_reg_arb_if.slave   bus
);

  localparam logic [0:0] c_state_idle  = 1'b0;
  localparam logic [0:0] c_state_grant = 1'b1;

  // Decoder output for r0; shifting right by the register number gives
  // the one-hot grant for any register.
  localparam logic [7:0] c_r0_onehot = 8'b1000_0000;

  logic [0:0] r_state;
  logic [2:0] r_reg_num;
  logic [7:0] r_grant;
  logic [2:0] r_ptr;

  logic [7:0] w_req_by_reg;  // bit i set when register ri is requesting
  logic       w_any_req;
  logic [2:0] w_base;        // first register examined by the scan
  logic [2:0] w_win;         // selected winner for the next latch

  // Reorder requests so that bit index equals register number.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_reorder
      assign w_req_by_reg[gi] = bus.req[7-gi];
    end
  endgenerate

  assign w_any_req = |bus.req;

  // Scan start: fixed priority always starts at r0; round-robin starts at
  // the pointer value that will be in effect after this edge, so an accept
  // and a new selection in the same cycle already see the advanced pointer.
  generate
    if (FIXED_PRIORITY) begin : g_fixed
      assign w_base = 3'd0;
    end else begin : g_rr
      logic w_accept;
      assign w_accept = (r_state == c_state_grant) && bus.ready;
      assign w_base   = w_accept ? (r_reg_num + 3'd1) : r_ptr;
    end
  endgenerate

  // Circular first-set scan from w_base, wrapping modulo 8.
  always_comb begin
    logic       v_found;
    logic [2:0] v_idx;
    v_found = 1'b0;
    v_idx   = 3'd0;
    w_win   = 3'd0;
    for (int k = 0; k < 8; k++) begin
      v_idx = w_base + 3'(k);
      if (!v_found && w_req_by_reg[v_idx]) begin
        v_found = 1'b1;
        w_win   = v_idx;
      end
    end
  end

  // Grant state machine: latch a winner from IDLE, hold while the consumer
  // stalls, and on accept either chain the next winner or return to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= c_state_idle;
      r_reg_num <= 3'd0;
      r_grant   <= 8'd0;
    end else begin
      case (r_state)
        c_state_idle: begin
          if (w_any_req) begin
            r_state   <= c_state_grant;
            r_reg_num <= w_win;
            r_grant   <= c_r0_onehot >> w_win;
          end
        end
        c_state_grant: begin
          // Without ready the grant is frozen; req changes are ignored.
          if (bus.ready) begin
            if (w_any_req) begin
              r_reg_num <= w_win;
              r_grant   <= c_r0_onehot >> w_win;
            end else begin
              r_state <= c_state_idle;
              r_grant <= 8'd0;
            end
          end
        end
        default: begin
          r_state <= c_state_idle;
          r_grant <= 8'd0;
        end
      endcase
    end
  end

  // Round-robin pointer advances past the accepted register, only on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= 3'd0;
    end else if ((r_state == c_state_grant) && bus.ready) begin
      r_ptr <= r_reg_num + 3'd1;
    end
  end

  assign bus.valid   = (r_state == c_state_grant);
  assign bus.reg_num = r_reg_num;
  assign bus.grant   = r_grant;
  assign bus.ptr     = r_ptr;

endmodule
`default_nettype wire

// File: tb/tb_encode_reg_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_encode_reg_arb
//  Description : Self-checking bench for encode_reg_arb. A round-robin
//                instance is checked against a queue of expected grants,
//                plus directed checks of reset, backpressure and pointer;
//                a fixed-priority instance runs alongside.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_encode_reg_arb;

  logic clk;
  logic rst;

  encode_reg_arb_if u_rr_if ();
  encode_reg_arb_if u_fp_if ();

  encode_reg_arb #(.FIXED_PRIORITY(1'b0)) u_dut_rr (
    .clk (clk),
    .rst (rst),
    .bus (u_rr_if.slave)
  );

  encode_reg_arb #(.FIXED_PRIORITY(1'b1)) u_dut_fp (
    .clk (clk),
    .rst (rst),
    .bus (u_fp_if.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Expected register numbers for the round-robin instance, in grant order
  logic [2:0] sb_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in this bench
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [2:0] r);
    sb_q.push_back(r);
  endtask

  // Pop the next expected grant and compare the live round-robin output
  task automatic check_grant(input string tag);
    logic [2:0] exp_r;
    logic [7:0] onehot;
    check({tag, "_sb_avail"}, 32'(sb_q.size() > 0), 1);
    if (sb_q.size() > 0) begin
      exp_r  = sb_q.pop_front();
      onehot = 8'b1000_0000;
      onehot = onehot >> exp_r;
      check({tag, "_valid"},   32'(u_rr_if.valid),   1);
      check({tag, "_reg_num"}, 32'(u_rr_if.reg_num), 32'(exp_r));
      check({tag, "_grant"},   32'(u_rr_if.grant),   32'(onehot));
    end
  endtask

  task automatic check_fp(input string tag, input logic [2:0] exp_r);
    logic [7:0] onehot;
    onehot = 8'b1000_0000;
    onehot = onehot >> exp_r;
    check({tag, "_valid"},   32'(u_fp_if.valid),   1);
    check({tag, "_reg_num"}, 32'(u_fp_if.reg_num), 32'(exp_r));
    check({tag, "_grant"},   32'(u_fp_if.grant),   32'(onehot));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    u_rr_if.req   = 8'hFF;
    u_rr_if.ready = 1'b0;
    u_fp_if.req   = 8'hFF;
    u_fp_if.ready = 1'b1;

    // Reset state with requests present
    step();
    step();
    check("rst_valid",   32'(u_rr_if.valid),   0);
    check("rst_grant",   32'(u_rr_if.grant),   0);
    check("rst_reg_num", 32'(u_rr_if.reg_num), 0);
    check("rst_ptr",     32'(u_rr_if.ptr),     0);
    check("rst_fp_valid", 32'(u_fp_if.valid),  0);

    // First grant one edge after reset release
    rst = 1'b0;
    push_exp(3'd0);
    step();
    check_grant("first");
    check("first_ptr", 32'(u_rr_if.ptr), 0);
    check_fp("fp_first", 3'd0);

    // Round-robin full load: 0,1,...,7,0,1 with ptr tracking each grant
    u_rr_if.ready = 1'b1;
    for (int i = 1; i < 10; i++) begin
      push_exp(3'(i % 8));
      step();
      check_grant("rr_load");
      check("rr_load_ptr", 32'(u_rr_if.ptr), 32'(i % 8));
      if (i <= 3) check_fp("fp_load", 3'd0);
    end

    // Accept r1, next winner among r2/r5 from ptr=2 is r2
    u_rr_if.req = 8'b0010_0100;
    push_exp(3'd2);
    step();
    check_grant("bp_first");
    check("bp_first_ptr", 32'(u_rr_if.ptr), 2);

    // Backpressure: grant and pointer frozen
    u_rr_if.ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp_hold_valid", 32'(u_rr_if.valid),   1);
      check("bp_hold_reg",   32'(u_rr_if.reg_num), 2);
      check("bp_hold_ptr",   32'(u_rr_if.ptr),     2);
    end

    // Withdrawn requests do not retract the grant
    u_rr_if.req = 8'h00;
    step();
    check("bp_drop_valid", 32'(u_rr_if.valid),   1);
    check("bp_drop_reg",   32'(u_rr_if.reg_num), 2);
    check("bp_drop_grant", 32'(u_rr_if.grant),   32'h20);

    // Accept r2 with only r5 requesting
    u_rr_if.ready = 1'b1;
    u_rr_if.req   = 8'b0000_0100;
    push_exp(3'd5);
    step();
    check_grant("bp_next");
    check("bp_next_ptr", 32'(u_rr_if.ptr), 3);

    // Pointer skip: accept r5 -> ptr=6, r1/r7 requesting -> r7
    u_rr_if.req = 8'b0100_0001;
    push_exp(3'd7);
    step();
    check_grant("skip");
    check("skip_ptr", 32'(u_rr_if.ptr), 6);

    // Wrap: accept r7 -> ptr=0, next r1
    push_exp(3'd1);
    step();
    check_grant("wrap");
    check("wrap_ptr", 32'(u_rr_if.ptr), 0);

    // Idle return: accept with no requests
    u_rr_if.req = 8'h00;
    step();
    check("idle_valid", 32'(u_rr_if.valid), 0);
    check("idle_grant", 32'(u_rr_if.grant), 0);
    check("idle_ptr",   32'(u_rr_if.ptr),   2);
    check("sb_drained", 32'(sb_q.size()),   0);

    // Grant r3 under backpressure, then reset between edges
    u_rr_if.req   = 8'b0001_0000;
    u_rr_if.ready = 1'b0;
    push_exp(3'd3);
    step();
    check_grant("pre_rst");
    check("pre_rst_ptr", 32'(u_rr_if.ptr), 2);
    #1 rst = 1'b1;
    #1;
    check("midrst_valid",   32'(u_rr_if.valid),   0);
    check("midrst_grant",   32'(u_rr_if.grant),   0);
    check("midrst_reg_num", 32'(u_rr_if.reg_num), 0);
    check("midrst_ptr",     32'(u_rr_if.ptr),     0);
    check("midrst_fp_valid", 32'(u_fp_if.valid),  0);
    #1 rst = 1'b0;

    // Fresh grant after reset, then single requester re-granted each accept
    push_exp(3'd3);
    step();
    check_grant("post_rst");
    check("post_rst_ptr", 32'(u_rr_if.ptr), 0);
    u_rr_if.ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_exp(3'd3);
      step();
      check_grant("single");
      check("single_ptr", 32'(u_rr_if.ptr), 4);
    end

    // Fixed priority picks the lowest-numbered requester regardless of ptr
    u_fp_if.req = 8'b0001_0001;
    step();
    check_fp("fp_low", 3'd3);
    step();
    check_fp("fp_low_again", 3'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/encode_reg_arb.md
# encode_reg_arb

Sequential encoder and arbiter for register-select requests, the reverse of the register decoder. It takes an 8-bit request vector in one-hot register order and grants one request at a time. For each grant it presents the 3-bit register number and a one-hot echo of the grant. The consumer (writeback/bus control) accepts each grant with a valid/ready handshake. Arbitration is round-robin by default.

## Interface
- FIXED_PRIORITY, default 0. 0 selects round-robin. 1 selects fixed priority with r0 highest and r7 lowest; in this mode the pointer is ignored.
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req  in  8  request vector, decoder bit order: bit7=r0, bit6=r1, …, bit0=r7; any number of bits may be set
- ready  in  1  consumer accepts the current grant when ready=1 and valid=1 in the same cycle
- valid  out  1  grant outputs hold a live grant
- reg_num  out  3  granted register number (r0=000 … r7=111)
- grant  out  8  one-hot grant in decoder bit order (r0=8'b10000000); all zeros when valid=0
- ptr  out  3  current round-robin start register; debug/verification visibility

## Operation
- State machine:
  - IDLE: valid=0, grant=0.
  - GRANT: valid=1; reg_num and grant are registered and held stable.
- IDLE → GRANT when req≠0 at a clock edge. The winner is latched at that edge.
- Winner selection, round-robin: the first set request scanning r(ptr), r(ptr+1), …, r7, r0, …, r(ptr−1), with the index wrapping mod 8.
- Winner selection, FIXED_PRIORITY=1: the lowest-numbered requesting register.
- GRANT, ready=0: all outputs are held. req changes are ignored, including withdrawal of the granted request. A grant is never retracted.
- GRANT, ready=1 (accept):
  - ptr ← reg_num+1 mod 8 (111 wraps to 000).
  - If req≠0 in the same cycle, the next winner is chosen using the updated ptr. State stays GRANT with valid still 1 and new reg_num/grant, giving one grant per cycle.
  - If req=0, the next state is IDLE.
- Encoding invariant: grant is exactly the decoder output for reg_num whenever valid=1.
- The module keeps no per-request memory. Requesters must hold req until they observe their grant accepted.

## Timing
- Reset (asynchronous, immediate) sets: state=IDLE, valid=0, reg_num=3'b000, grant=8'b0, ptr=3'b000.
- Reset asserted mid-grant: outputs clear immediately. A pending grant is dropped, not replayed.
- Deassertion of reset is synchronous to the next clock edge. The first grant can be latched on the first edge after reset is low.
- Latency: req sampled at edge N → valid/reg_num/grant visible after edge N (one cycle). Combinational paths from req or ready to any output are forbidden.
- Throughput: one accepted grant per cycle while ready=1 and requests are pending.
- ptr updates only on accept, never on grant-without-accept.
- Boundary cases:
  - A single requester repeatedly re-requesting is granted every accept.
  - All 8 requesting with ready=1 continuously: grant order r(ptr) … wrapping, each register exactly once per 8 accepts.

## Test plan
- Reset check: assert reset with req=8'hFF → valid=0, grant=00, reg_num=000, ptr=000. Release reset → first grant r0 (grant=8'b10000000, reg_num=000) one edge later.
- Round-robin full load: req=8'hFF, ready=1 for 10 cycles → reg_num sequence 0,1,2,3,4,5,6,7,0,1; ptr follows +1 with 7→0 wrap; valid stays 1.
- Hold under backpressure: req=8'b00100100 (r2,r5), ready=0 for 4 cycles → reg_num=010 stable. Drop req mid-hold → output unchanged. ready=1 with req=8'b00000100 → next grant r5 (reg_num=101), then ptr=110.
- Pointer skip and wrap: ptr=110, req=8'b01000001 (r1,r7) → grant r7 (reg_num=111, grant=8'b00000001). Accept → ptr=000, next grant r1.
- Fixed priority build (FIXED_PRIORITY=1): req=8'hFF, ready=1 for 3 cycles → grant r0 every cycle, reg_num=000.
- Reset mid-grant and idle return: granted r3 with ready=0, then pulse reset between edges → valid drops immediately and ptr=000. Separately, accept with req=0 → valid=0 and grant=8'b0 after that edge.
